// File: rtl/norm_round_pack_f64_pkg.sv
// Shared constants for the binary64 normalize/round/pack engine:
// FSM encodings, rounding position and exponent limits.
package norm_round_pack_f64_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_NORM   = 3'd1;
  localparam logic [2:0] ST_DENORM = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [9:0]  ROUND_INC  = 10'h200;
  localparam int          ROUND_BITS = 10;
  localparam int          EXP_OVF    = 'h7FD;
  localparam logic [10:0] EXP_INF    = 11'h7FF;
  localparam logic [6:0]  DENORM_CAP = 7'd64;

endpackage

// File: rtl/norm_round_pack_f64.sv
// Multi-cycle binary64 normalize/round/pack engine (round-to-nearest-even),
// callee side of an ap_ctrl_hs handshake.
module norm_round_pack_f64
  import norm_round_pack_f64_pkg::*;
#(
  parameter int EXP_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  input  logic             z_sign,
  input  logic [EXP_W-1:0] z_exp,
  input  logic [63:0]      z_sig,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic [63:0]      ap_return
);

  localparam logic signed [EXP_W-1:0] EXP_OVF_W = EXP_W'(EXP_OVF);

  logic [2:0]              state;
  logic                    sign;
  logic signed [EXP_W-1:0] exp;
  logic [63:0]             sig;
  logic [6:0]              cnt;

  logic [63:0]      sig_inc;
  logic [53:0]      m_raw;
  logic [53:0]      m_rnd;
  logic [10:0]      exp_field;
  logic             ovf;
  logic [EXP_W-1:0] neg_exp;
  logic [6:0]       denorm_cnt;

  assign sig_inc = sig + 64'(ROUND_INC);
  assign m_raw   = sig_inc[63:ROUND_BITS];
  // An exact half-way remainder rounds to even by dropping the lsb.
  assign m_rnd   = (sig[ROUND_BITS-1:0] == ROUND_INC) ? {m_raw[53:1], 1'b0} : m_raw;
  assign exp_field = (m_rnd == '0) ? 11'd0 : exp[10:0];

  assign ovf = (exp > EXP_OVF_W) || ((exp == EXP_OVF_W) && sig_inc[63]);

  assign neg_exp    = -exp;
  assign denorm_cnt = (neg_exp >= EXP_W'(DENORM_CAP)) ? DENORM_CAP : neg_exp[6:0];

  assign ap_done  = (state == ST_DONE);
  assign ap_ready = (state == ST_DONE);
  assign ap_idle  = (state == ST_IDLE) && !ap_start;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= ST_IDLE;
      sign      <= 1'b0;
      exp       <= '0;
      sig       <= '0;
      cnt       <= '0;
      ap_return <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ap_start) begin
            sign  <= z_sign;
            exp   <= z_exp;
            sig   <= z_sig;
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (sig == '0) begin
            ap_return <= {sign, 63'b0};
            state     <= ST_DONE;
          end else if (sig[63:62] == 2'b00) begin
            sig <= {sig[62:0], 1'b0};
            exp <= exp - EXP_W'(1);
          end else if (ovf) begin
            ap_return <= {sign, EXP_INF, 52'b0};
            state     <= ST_DONE;
          end else if (exp[EXP_W-1]) begin
            cnt   <= denorm_cnt;
            exp   <= '0;
            state <= ST_DENORM;
          end else begin
            state <= ST_ROUND;
          end
        end
        // One-place right shift per cycle; bits leaving the bottom stick in bit 0.
        ST_DENORM: begin
          sig <= {1'b0, sig[63:2], sig[1] | sig[0]};
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) state <= ST_ROUND;
        end
        ST_ROUND: begin
          ap_return <= {sign, 63'b0} + {1'b0, exp_field, 52'b0} + {10'b0, m_rnd};
          state     <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/norm_round_pack_f64.md
# norm_round_pack_f64

Multi-cycle IEEE-754 binary64 normalize/round/pack engine, the callee end of the ap_ctrl_hs block-level handshake that the float64 top-level wrappers use to launch their sub-functions. It accepts a sign, a signed working exponent and a 64-bit working significand, then returns the packed double. Semantics match SoftFloat `normalizeRoundAndPackFloat64` with round-to-nearest-even and no exception flags. It sits beside the add/sub significand helpers as the shared post-processing stage.

## Interface
- EXP_W, 16, working exponent width (signed, two's complement)
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- ap_start  in  1  caller request; held high by the caller until it samples ap_ready
- z_sign  in  1  result sign
- z_exp  in  EXP_W  working exponent, signed
- z_sig  in  64  working significand; hidden bit at bit 62, round bits [9:0]
- ap_done  out  1  one-cycle pulse, ap_return valid
- ap_idle  out  1  high in IDLE while ap_start is low
- ap_ready  out  1  same cycle as ap_done
- ap_return  out  64  packed double; held until the next ap_done

## Operation
- States: IDLE, NORM, DENORM, ROUND, DONE. Reset state is IDLE.
- Reset values: ap_return=0, ap_done=0, ap_ready=0. ap_idle=1 when ap_start is low.
- IDLE: on ap_start=1, latch z_sign, z_exp and z_sig into sign/exp/sig registers and go to NORM.
- NORM is evaluated in priority order:
  - sig==0: return {sign,63'b0} and go to DONE.
  - sig[63:62]==0: sig<<=1, exp-=1, stay in NORM.
  - Otherwise, check for overflow: exp>0x7FD (signed), or exp==0x7FD and bit 63 of (sig+0x200) is set. On overflow, return {sign,11'h7FF,52'b0} and go to DONE.
  - Otherwise, if exp<0: set cnt=min(-exp,64), exp=0, go to DENORM.
  - Otherwise go to ROUND.
- DENORM: each cycle, shift right one place with jamming: sig={1'b0,sig[63:1]}, and sig[0] becomes sig[1]|sig[0] (old values). Decrement cnt; go to ROUND when cnt reaches 0.
- ROUND:
  - r=sig[9:0], m=(sig+0x200)>>10 (54 bits).
  - If r==0x200, clear m[0].
  - If m==0, use exp=0.
  - ap_return = ({sign,63'b0} + (exp[10:0]<<52) + m) mod 2^64. A carry out of m[52] increments the exponent field by design.
  - Go to DONE.
- DONE: assert ap_done=ap_ready=1 for one cycle, then return to IDLE. ap_start is ignored during DONE.
- A z_sig[63]=1 input performs no normalization shift; the overflow and round paths handle it.
- The caller guarantees that exp does not wrap the EXP_W range during normalization.
- Reset asserted mid-operation: return to IDLE immediately. No ap_done pulse for the aborted request, and ap_return is cleared.

## Timing
- Count cycles from the accept cycle (IDLE with ap_start=1) as cycle 0. L = number of NORM left shifts, D = min(-exp_after_norm,64), or 0 if not underflowed.
- Normal or denormal result: ap_done in cycle L+D+3.
- Overflow: ap_done in cycle L+2.
- Zero significand: ap_done in cycle 2.
- Back-to-back requests: if ap_start is still high in the cycle after DONE, a new request is accepted in that IDLE cycle.
- Maximum latency: 62+64+3 = 129 cycles.
- ap_idle=0 from cycle 1 through DONE.

## Structure
- Package norm_round_pack_f64_pkg holds:
  - state enum
  - ROUND_INC=10'h200, ROUND_BITS=10
  - EXP_OVF=0x7FD, EXP_INF=11'h7FF
  - DENORM_CAP=64
- Single module, no sub-module. The sticky right shift is a one-bit-per-cycle datapath inside DENORM.

## Test plan
- z_sign=0, z_exp=0x3FE, z_sig=0x4000_0000_0000_0000 -> ap_return=0x3FF0_0000_0000_0000, ap_done in cycle 3.
- z_exp=0x400, z_sig=0x1000_0000_0000_0000 -> L=2, ap_return=0x3FF0_0000_0000_0000, ap_done in cycle 5.
- Tie-to-even, both with z_exp=0x3FE:
  - z_sig=0x4000_0000_0000_0200 -> 0x3FF0_0000_0000_0000
  - z_sig=0x4000_0000_0000_0600 -> 0x3FF0_0000_0000_0002
- Overflow, z_exp=0x7FD, z_sig=0x7FFF_FFFF_FFFF_FE00:
  - z_sign=0 -> 0x7FF0_0000_0000_0000, ap_done in cycle 2
  - z_sign=1 -> 0xFFF0_0000_0000_0000
- Denormal: z_exp=16'hFFFE, z_sig=0x4000_0000_0000_0000 -> 0x0004_0000_0000_0000, ap_done in cycle 5.
- Zero and reset:
  - z_sign=1, z_sig=0 -> 0x8000_0000_0000_0000 in cycle 2.
  - Drop ap_rst_n during NORM -> ap_idle=1 and ap_return=0 immediately, no ap_done pulse.
